prio_enc_seq: RTL and testbench

Parametrised, clocked successor to the 4-to-2 encoder family. It captures an N-bit request word (active-low or active-high), then emits the index of every asserted request one at a time, highest priority first, over a valid/ready handshake. It sits between a request source (buttons, interrupt lines, status flags) and a consumer that services one index per transfer. It replaces single-shot combinational encoding with full servicing of every simultaneous request.

---
 rtl/prio_enc_seq.sv | 112 +++++++++++
 tb/tb_prio_enc_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: captures a request word and emits every asserted index, highest priority first.
// Latency: first index is valid the cycle after the load edge; one index per cycle while ready is high.
// Backpressure: with ready low, the pending word and y hold; load is ignored until the word is drained.
module prio_enc_seq #(
  parameter int N          = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int LSB_FIRST  = 1,
  localparam int W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] w,
  input  logic         load,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         none
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         done_q, done_d;
  logic         none_q, none_d;

  logic [N-1:0] norm_w;
  logic [W-1:0] idx;

  // Pick the winning index of a request vector; the last match written wins,
  // so the scan direction is the reverse of the priority order.
  function automatic logic [W-1:0] prio_idx(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) r = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) r = W'(i);
      end
    end
    return r;
  endfunction

  // Normalise request polarity so pend always holds 1 = asserted.
  assign norm_w = (ACTIVE_LOW != 0) ? ~w : w;

  // Index is decoded from the register only, so y moves only on clock edges.
  assign idx   = prio_idx(pend_q);
  assign valid = (state_q == SCAN);
  assign busy  = (state_q == SCAN);
  assign y     = (state_q == SCAN) ? idx : '0;
  assign done  = done_q;
  assign none  = none_q;

  // Next-state: capture from IDLE, retire one index per accepted transfer in SCAN.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    none_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (|norm_w) begin
            pend_d  = norm_w;
            state_d = SCAN;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // load is deliberately ignored here, even on the final transfer.
        if (ready) begin
          pend_d[idx] = 1'b0;
          if (pend_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State and data registers; reset overrides everything and suppresses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_prio_enc_seq.sv
// Directed bench for prio_enc_seq across three configurations sharing one clock.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants.
module tb_prio_enc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: N=4 active-low LSB-first; b: N=4 active-low MSB-first; c: N=8 active-high LSB-first
  logic       rst_a, load_a, ready_a; logic [3:0] w_a;
  logic [1:0] y_a; logic valid_a, busy_a, done_a, none_a;
  logic       rst_b, load_b, ready_b; logic [3:0] w_b;
  logic [1:0] y_b; logic valid_b, busy_b, done_b, none_b;
  logic       rst_c, load_c, ready_c; logic [7:0] w_c;
  logic [2:0] y_c; logic valid_c, busy_c, done_c, none_c;

  prio_enc_seq #(.N(4), .ACTIVE_LOW(1), .LSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst_a), .w(w_a), .load(load_a), .ready(ready_a),
    .y(y_a), .valid(valid_a), .busy(busy_a), .done(done_a), .none(none_a));
  prio_enc_seq #(.N(4), .ACTIVE_LOW(1), .LSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst_b), .w(w_b), .load(load_b), .ready(ready_b),
    .y(y_b), .valid(valid_b), .busy(busy_b), .done(done_b), .none(none_b));
  prio_enc_seq #(.N(8), .ACTIVE_LOW(0), .LSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst_c), .w(w_c), .load(load_c), .ready(ready_c),
    .y(y_c), .valid(valid_c), .busy(busy_c), .done(done_c), .none(none_c));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] wa_tab [4];
  logic [1:0] ya_tab [4];
  logic [2:0] yc_tab [5];
  logic       rc_tab [5];

  initial begin
    wa_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ya_tab = '{2'd0, 2'd1, 2'd2, 2'd3};
    yc_tab = '{3'd1, 3'd4, 3'd4, 3'd4, 3'd7};
    rc_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_a = 1; load_a = 0; ready_a = 1; w_a = 4'hF;
    rst_b = 1; load_b = 0; ready_b = 1; w_b = 4'hF;
    rst_c = 1; load_c = 0; ready_c = 1; w_c = 8'h00;
    tick(); tick();
    check_eq("rst_y",     64'(y_a),     64'd0);
    check_eq("rst_valid", 64'(valid_a), 64'd0);
    check_eq("rst_busy",  64'(busy_a),  64'd0);
    check_eq("rst_done",  64'(done_a),  64'd0);
    check_eq("rst_none",  64'(none_a),  64'd0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    tick();

    // single requests, ready held high
    for (int i = 0; i < 4; i++) begin
      w_a = wa_tab[i]; load_a = 1;
      tick();
      load_a = 0; w_a = 4'hF;
      check_eq($sformatf("single%0d_y", i), 64'(y_a), 64'(ya_tab[i]));
      check_eq($sformatf("single%0d_valid", i), 64'(valid_a), 64'd1);
      check_eq($sformatf("single%0d_busy", i), 64'(busy_a), 64'd1);
      tick();
      check_eq($sformatf("single%0d_done", i), 64'(done_a), 64'd1);
      check_eq($sformatf("single%0d_valid_off", i), 64'(valid_a), 64'd0);
      check_eq($sformatf("single%0d_busy_off", i), 64'(busy_a), 64'd0);
    end

    // no requests asserted
    w_a = 4'b1111; load_a = 1;
    tick();
    load_a = 0;
    check_eq("none_pulse", 64'(none_a),  64'd1);
    check_eq("none_valid", 64'(valid_a), 64'd0);
    check_eq("none_busy",  64'(busy_a),  64'd0);
    tick();
    check_eq("none_clear", 64'(none_a),  64'd0);
    check_eq("none_busy2", 64'(busy_a),  64'd0);

    // all requests, both priority orders in parallel
    w_a = 4'b0000; load_a = 1; w_b = 4'b0000; load_b = 1;
    tick();
    load_a = 0; load_b = 0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("all_lsb%0d", i), 64'(y_a), 64'(i));
      check_eq($sformatf("all_msb%0d", i), 64'(y_b), 64'(3 - i));
      check_eq($sformatf("all_valid%0d", i), 64'(valid_a), 64'd1);
      tick();
    end
    check_eq("all_lsb_done", 64'(done_a), 64'd1);
    check_eq("all_msb_done", 64'(done_b), 64'd1);
    check_eq("all_done_gone_next", 64'(valid_b), 64'd0);

    // back-to-back: load accepted in the done cycle
    w_a = 4'b1110; load_a = 1;
    tick();
    load_a = 0;
    check_eq("b2b_first_y", 64'(y_a), 64'd0);
    tick();
    check_eq("b2b_done", 64'(done_a), 64'd1);
    w_a = 4'b0011; load_a = 1;
    tick();
    load_a = 0; w_a = 4'hF;
    check_eq("b2b_y2",     64'(y_a),     64'd2);
    check_eq("b2b_valid2", 64'(valid_a), 64'd1);
    tick();
    check_eq("b2b_y3", 64'(y_a), 64'd3);
    tick();
    check_eq("b2b_done2", 64'(done_a), 64'd1);

    // active-high N=8 with backpressure and an ignored mid-scan load
    w_c = 8'b1001_0010; load_c = 1;
    tick();
    load_c = 0; w_c = 8'h00;
    for (int i = 0; i < 5; i++) begin
      ready_c = rc_tab[i];
      if (i == 1) begin
        load_c = 1; w_c = 8'hFF;
      end else begin
        load_c = 0; w_c = 8'h00;
      end
      check_eq($sformatf("bp%0d_y", i), 64'(y_c), 64'(yc_tab[i]));
      check_eq($sformatf("bp%0d_valid", i), 64'(valid_c), 64'd1);
      check_eq($sformatf("bp%0d_done", i), 64'(done_c), 64'd0);
      tick();
    end
    load_c = 0; ready_c = 1;
    check_eq("bp_done",  64'(done_c),  64'd1);
    check_eq("bp_valid", 64'(valid_c), 64'd0);
    tick();
    check_eq("bp_load_ignored", 64'(busy_c), 64'd0);

    // reset in the middle of a scan
    w_c = 8'hFF; load_c = 1;
    tick();
    load_c = 0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ff%0d_y", i), 64'(y_c), 64'(i));
      tick();
    end
    check_eq("ff3_y", 64'(y_c), 64'd3);
    rst_c = 1;
    tick();
    rst_c = 0;
    check_eq("mid_rst_valid", 64'(valid_c), 64'd0);
    check_eq("mid_rst_busy",  64'(busy_c),  64'd0);
    check_eq("mid_rst_y",     64'(y_c),     64'd0);
    check_eq("mid_rst_done",  64'(done_c),  64'd0);
    tick();
    check_eq("mid_rst_done2", 64'(done_c),  64'd0);
    check_eq("mid_rst_idle",  64'(busy_c),  64'd0);
    w_c = 8'h80; load_c = 1;
    tick();
    load_c = 0;
    check_eq("post_rst_y",     64'(y_c),     64'd7);
    check_eq("post_rst_valid", 64'(valid_c), 64'd1);
    tick();
    check_eq("post_rst_done",  64'(done_c),  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
